// File: rtl/letter_pool_pkg.sv
// Shared types and field widths for the falling-letter pool.
package letter_pool_pkg;

    localparam int unsigned CH_W  = 8;
    localparam int unsigned SPD_W = 4;
    localparam int unsigned X_W   = 9;
    localparam int unsigned Y_W   = 10;

    typedef enum logic [1:0] {
        StIdle,
        StSpawn,
        StMove,
        StMatch
    } state_t;

    typedef struct packed {
        logic             active;
        logic [CH_W-1:0]  ch;
        logic [SPD_W-1:0] speed;
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
    } slot_t;

    // Counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/letter_pool_if.sv
// Bundle of event, generator, renderer and status signals of letter_pool.
interface letter_pool_if
    import letter_pool_pkg::*;
#(
    parameter int unsigned SLOTS = 8
);
    localparam int unsigned IDX_W = $clog2(SLOTS);

    logic             frame_tick;
    logic [CH_W-1:0]  gen_ch;
    logic [SPD_W-1:0] gen_speed;
    logic [X_W-1:0]   gen_x;
    logic [Y_W-1:0]   gen_y;
    logic             key_valid;
    logic [CH_W-1:0]  key_code;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_active;
    logic [CH_W-1:0]  rd_ch;
    logic [X_W-1:0]   rd_x;
    logic [Y_W-1:0]   rd_y;
    logic [15:0]      score;
    logic [15:0]      miss;
    logic             busy;
    logic             game_over;

    modport master (
        output frame_tick, gen_ch, gen_speed, gen_x, gen_y, key_valid, key_code, rd_idx,
        input  rd_active, rd_ch, rd_x, rd_y, score, miss, busy, game_over
    );

    modport slave (
        input  frame_tick, gen_ch, gen_speed, gen_x, gen_y, key_valid, key_code, rd_idx,
        output rd_active, rd_ch, rd_x, rd_y, score, miss, busy, game_over
    );

endinterface

// File: rtl/lp_first_set.sv
// Lowest-index priority encoder: reports whether any request bit is set and its index.
module lp_first_set #(
    parameter int unsigned N = 8,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/letter_pool.sv
// Pool of falling letters: spawns from the generator, moves once per frame,
// retires letters on a matching keystroke or when they fall past the bottom row.
// Optional feature: define LETTER_POOL_GAMEOVER_EN to stop play after MISS_MAX misses.
module letter_pool
    import letter_pool_pkg::*;
#(
    parameter int unsigned    SLOTS        = 8,
    parameter int unsigned    SPAWN_FRAMES = 60,
    parameter logic [X_W-1:0] X_LIMIT      = 9'd464,
    parameter logic [15:0]    MISS_MAX     = 16'd10
) (
    input logic          clk,
    input logic          rst_n,
    letter_pool_if.slave bus
);

    localparam int unsigned IDX_W      = $clog2(SLOTS);
    localparam logic [7:0]  SPAWN_LAST = 8'(SPAWN_FRAMES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

    state_t           state_q, state_d;
    slot_t            slots_q [SLOTS];
    slot_t            slots_d [SLOTS];
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             frame_pend_q, frame_pend_d;
    logic             key_pend_q, key_pend_d;
    logic [CH_W-1:0]  key_q, key_d;
    logic [IDX_W-1:0] move_idx_q, move_idx_d;
    logic [15:0]      score_q, score_d;
    logic [15:0]      miss_q, miss_d;
    logic             events_en;

    logic [SLOTS-1:0] free_req, match_req;
    logic             free_found, match_found;
    logic [IDX_W-1:0] free_idx, match_idx;
    slot_t            cur;
    logic [X_W:0]     x_new;
    slot_t            rd_slot;

`ifdef LETTER_POOL_GAMEOVER_EN
    logic game_over_q;

    // Latch end of game one cycle after the miss count reaches its limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            game_over_q <= 1'b0;
        end else if (miss_q >= MISS_MAX) begin
            game_over_q <= 1'b1;
        end
    end

    assign events_en     = ~game_over_q;
    assign bus.game_over = game_over_q;
`else
    logic unused_miss_max;
    assign unused_miss_max = ^MISS_MAX;
    assign events_en       = 1'b1;
    assign bus.game_over   = 1'b0;
`endif

    // Request vectors for the free-slot search and the key match.
    always_comb begin
        free_req  = '0;
        match_req = '0;
        for (int i = 0; i < SLOTS; i++) begin
            free_req[i]  = ~slots_q[i].active;
            match_req[i] = slots_q[i].active && (slots_q[i].ch == key_q);
        end
    end

    lp_first_set #(.N(SLOTS)) u_free (
        .req   (free_req),
        .found (free_found),
        .idx   (free_idx)
    );

    lp_first_set #(.N(SLOTS)) u_match (
        .req   (match_req),
        .found (match_found),
        .idx   (match_idx)
    );

    // Next-state: event capture, spawn, per-slot move and key match.
    always_comb begin
        state_d      = state_q;
        slots_d      = slots_q;
        frame_cnt_d  = frame_cnt_q;
        frame_pend_d = frame_pend_q | (bus.frame_tick & events_en);
        key_pend_d   = key_pend_q;
        key_d        = key_q;
        move_idx_d   = move_idx_q;
        score_d      = score_q;
        miss_d       = miss_q;
        cur          = slots_q[move_idx_q];
        x_new        = {1'b0, cur.x} + {{(X_W + 1 - SPD_W){1'b0}}, cur.speed};

        // The code is captured with the strobe; a repeat while pending is dropped.
        if (bus.key_valid && !key_pend_q && events_en) begin
            key_pend_d = 1'b1;
            key_d      = bus.key_code;
        end

        unique case (state_q)
            StIdle: begin
                if (events_en) begin
                    if (frame_pend_q) begin
                        state_d = StSpawn;
                    end else if (key_pend_q) begin
                        state_d = StMatch;
                    end
                end
            end
            StSpawn: begin
                frame_pend_d = 1'b0;
                if (frame_cnt_q == SPAWN_LAST) begin
                    frame_cnt_d = '0;
                    if (free_found) begin
                        slots_d[free_idx].active = 1'b1;
                        slots_d[free_idx].ch     = bus.gen_ch;
                        slots_d[free_idx].speed  = bus.gen_speed;
                        slots_d[free_idx].x      = bus.gen_x;
                        slots_d[free_idx].y      = bus.gen_y;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
                move_idx_d = '0;
                state_d    = StMove;
            end
            StMove: begin
                if (cur.active) begin
                    if (x_new >= {1'b0, X_LIMIT}) begin
                        slots_d[move_idx_q].active = 1'b0;
                        miss_d = sat_inc16(miss_q);
                    end else begin
                        slots_d[move_idx_q].x = x_new[X_W-1:0];
                    end
                end
                if (move_idx_q == LAST_IDX) begin
                    state_d = StIdle;
                end else begin
                    move_idx_d = move_idx_q + 1'b1;
                end
            end
            StMatch: begin
                key_pend_d = 1'b0;
                if (match_found) begin
                    slots_d[match_idx].active = 1'b0;
                    score_d = sat_inc16(score_q);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset aborts any pass in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            for (int i = 0; i < SLOTS; i++) begin
                slots_q[i] <= '0;
            end
            frame_cnt_q  <= '0;
            frame_pend_q <= 1'b0;
            key_pend_q   <= 1'b0;
            key_q        <= '0;
            move_idx_q   <= '0;
            score_q      <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            slots_q      <= slots_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_pend_q <= frame_pend_d;
            key_pend_q   <= key_pend_d;
            key_q        <= key_d;
            move_idx_q   <= move_idx_d;
            score_q      <= score_d;
            miss_q       <= miss_d;
        end
    end

    // Renderer view; out-of-range indices read as an empty slot.
    always_comb begin
        rd_slot = '0;
        if (32'(bus.rd_idx) < SLOTS) begin
            rd_slot = slots_q[bus.rd_idx];
        end
    end

    assign bus.rd_active = rd_slot.active;
    assign bus.rd_ch     = rd_slot.ch;
    assign bus.rd_x      = rd_slot.x;
    assign bus.rd_y      = rd_slot.y;
    assign bus.score     = score_q;
    assign bus.miss      = miss_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_letter_pool.sv
// Self-checking bench for letter_pool against a frame/key-level reference model.
module tb_letter_pool;
    import letter_pool_pkg::*;

    localparam int NS = 8;
    localparam int SF = 1;
    localparam int XL = 464;
    localparam int MM = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    letter_pool_if #(.SLOTS(NS)) bus ();
    letter_pool_if #(.SLOTS(NS)) bus3 ();

    letter_pool #(
        .SLOTS(NS), .SPAWN_FRAMES(SF), .X_LIMIT(9'd464), .MISS_MAX(16'd2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    letter_pool #(
        .SLOTS(NS), .SPAWN_FRAMES(3), .X_LIMIT(9'd464), .MISS_MAX(16'd2)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    // Reference model: whole-frame and whole-keystroke effects.
    bit m_act [NS];
    int m_ch [NS], m_spd [NS], m_x [NS], m_y [NS];
    int m_cnt, m_score, m_miss;
    bit m_go;

    logic       d_act [NS];
    logic [7:0] d_ch [NS];
    logic [8:0] d_x [NS];
    logic [9:0] d_y [NS];

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_ch[i] = 0; m_spd[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cnt = 0; m_score = 0; m_miss = 0; m_go = 0;
    endtask

    task automatic model_frame(input int ch, input int spd, input int x, input int y);
        int f;
        int nx;
        if (m_go) return;
        if (m_cnt == SF - 1) begin
            m_cnt = 0;
            f = -1;
            for (int i = 0; i < NS; i++) if (!m_act[i] && f < 0) f = i;
            if (f >= 0) begin
                m_act[f] = 1; m_ch[f] = ch; m_spd[f] = spd; m_x[f] = x; m_y[f] = y;
            end
        end else begin
            m_cnt++;
        end
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                nx = m_x[i] + m_spd[i];
                if (nx >= XL) begin
                    m_act[i] = 0;
                    if (m_miss < 65535) m_miss++;
                end else begin
                    m_x[i] = nx;
                end
            end
        end
`ifdef LETTER_POOL_GAMEOVER_EN
        if (m_miss >= MM) m_go = 1;
`endif
    endtask

    task automatic model_key(input int k);
        if (m_go) return;
        for (int i = 0; i < NS; i++) begin
            if (m_act[i] && m_ch[i] == k) begin
                m_act[i] = 0;
                if (m_score < 65535) m_score++;
                return;
            end
        end
    endtask

    task automatic snap();
        for (int i = 0; i < NS; i++) begin
            bus.rd_idx = 3'(i);
            #1;
            d_act[i] = bus.rd_active; d_ch[i] = bus.rd_ch; d_x[i] = bus.rd_x; d_y[i] = bus.rd_y;
        end
    endtask

    task automatic drive_idle();
        bus.frame_tick = 0; bus.key_valid = 0; bus.key_code = 0; bus.rd_idx = 0;
        bus.gen_ch = 0; bus.gen_speed = 0; bus.gen_x = 0; bus.gen_y = 0;
        bus3.frame_tick = 0; bus3.key_valid = 0; bus3.key_code = 0; bus3.rd_idx = 0;
        bus3.gen_ch = 0; bus3.gen_speed = 0; bus3.gen_x = 0; bus3.gen_y = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
    endtask

    task automatic set_gen(input int ch, input int spd, input int x, input int y);
        bus.gen_ch = 8'(ch); bus.gen_speed = 4'(spd); bus.gen_x = 9'(x); bus.gen_y = 10'(y);
    endtask

    task automatic pulse(input bit f, input bit k);
        @(posedge clk); #1;
        bus.frame_tick = f; bus.key_valid = k;
        @(posedge clk); #1;
        bus.frame_tick = 0; bus.key_valid = 0;
    endtask

    // Idle means busy low for three consecutive cycles (covers MOVE->IDLE->MATCH).
    task automatic wait_idle();
        int quiet = 0;
        for (int c = 0; c < 200 && quiet < 3; c++) begin
            @(posedge clk); #1;
            if (bus.busy) quiet = 0; else quiet++;
        end
        if (quiet < 3) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy still %0d, want 0", bus.busy);
        end
    endtask

    task automatic frame(input int ch, input int spd, input int x, input int y);
        set_gen(ch, spd, x, y);
        pulse(1, 0);
        wait_idle();
        model_frame(ch, spd, x, y);
    endtask

    task automatic key(input int k);
        bus.key_code = 8'(k);
        pulse(0, 1);
        wait_idle();
        model_key(k);
    endtask

    task automatic test_reset();
        do_reset();
        snap();
        for (int i = 0; i < NS; i++) begin
            checks++;
            if ({d_act[i], d_ch[i], d_x[i], d_y[i]} !== 28'd0) begin
                errors++;
                $display("FAIL reset_slot%0d: got act=%0d ch=%0d x=%0d y=%0d, want all 0",
                         i, d_act[i], d_ch[i], d_x[i], d_y[i]);
            end
        end
        checks++;
        if ({bus.score, bus.miss, bus.busy, bus.game_over} !== 34'd0) begin
            errors++;
            $display("FAIL reset_status: got score=%0d miss=%0d busy=%0d go=%0d, want 0",
                     bus.score, bus.miss, bus.busy, bus.game_over);
        end
    endtask

    task automatic test_spawn_move();
        int n = 0;
        bit seen = 0;
        do_reset();
        set_gen("a", 2, 0, 90);
        pulse(1, 0);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.busy) begin n++; seen = 1; end
            else if (seen) break;
        end
        checks++;
        if (n != 1 + NS) begin
            errors++;
            $display("FAIL busy_cycles: got %0d, want %0d", n, 1 + NS);
        end
        wait_idle();
        model_frame("a", 2, 0, 90);
        snap();
        checks++;
        if (d_act[0] !== 1'b1 || d_ch[0] !== 8'h61 || d_x[0] !== 9'd2 || d_y[0] !== 10'd90) begin
            errors++;
            $display("FAIL spawn_slot0: got act=%0d ch=%0d x=%0d y=%0d, want 1 97 2 90",
                     d_act[0], d_ch[0], d_x[0], d_y[0]);
        end
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (d_act[i] !== m_act[i]) begin
                errors++;
                $display("FAIL spawn_act%0d: got %0d, want %0d", i, d_act[i], m_act[i]);
            end
        end
    endtask

    task automatic test_miss();
        do_reset();
        frame("a", 4, 456, 7);
        snap();
        checks++;
        if (d_act[0] !== 1'b1 || d_x[0] !== 9'd460) begin
            errors++;
            $display("FAIL miss_pre: got act=%0d x=%0d, want 1 460", d_act[0], d_x[0]);
        end
        frame("q", 0, 0, 0);
        snap();
        checks++;
        if (d_act[0] !== 1'b0 || bus.miss !== 16'd1 || bus.miss !== 16'(m_miss)) begin
            errors++;
            $display("FAIL miss_post: got act=%0d miss=%0d, want 0 1", d_act[0], bus.miss);
        end
        checks++;
        if (d_act[1] !== 1'b1 || d_ch[1] !== 8'(m_ch[1]) || d_x[1] !== 9'(m_x[1])) begin
            errors++;
            $display("FAIL miss_slot1: got act=%0d ch=%0d x=%0d, want 1 %0d %0d",
                     d_act[1], d_ch[1], d_x[1], m_ch[1], m_x[1]);
        end
    endtask

    task automatic test_match();
        int chars [6] = '{"k", "b", "c", "k", "e", "k"};
        do_reset();
        for (int i = 0; i < 6; i++) frame(chars[i], 0, 10 * i, i);
        key("k");
        snap();
        checks++;
        if (d_act[0] !== 1'b0 || d_act[3] !== 1'b1 || d_act[5] !== 1'b1 || bus.score !== 16'd1) begin
            errors++;
            $display("FAIL match_k: got s0=%0d s3=%0d s5=%0d score=%0d, want 0 1 1 1",
                     d_act[0], d_act[3], d_act[5], bus.score);
        end
        key("z");
        snap();
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (d_act[i] !== m_act[i] || (m_act[i] && (d_ch[i] !== 8'(m_ch[i])
                || d_x[i] !== 9'(m_x[i])))) begin
                errors++;
                $display("FAIL match_z_slot%0d: got act=%0d ch=%0d x=%0d, want %0d %0d %0d",
                         i, d_act[i], d_ch[i], d_x[i], m_act[i], m_ch[i], m_x[i]);
            end
        end
        checks++;
        if (bus.score !== 16'(m_score)) begin
            errors++;
            $display("FAIL match_z_score: got %0d, want %0d", bus.score, m_score);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < NS; i++) frame("a" + i, 0, 20 + i, 100 + i);
        frame("z", 3, 1, 1);
        snap();
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (d_act[i] !== 1'b1 || d_ch[i] !== 8'(m_ch[i]) || d_x[i] !== 9'(m_x[i])
                || d_y[i] !== 10'(m_y[i])) begin
                errors++;
                $display("FAIL full_slot%0d: got act=%0d ch=%0d x=%0d y=%0d, want 1 %0d %0d %0d",
                         i, d_act[i], d_ch[i], d_x[i], d_y[i], m_ch[i], m_x[i], m_y[i]);
            end
        end
        checks++;
        if (bus.score !== 16'd0 || bus.miss !== 16'd0) begin
            errors++;
            $display("FAIL full_counts: got score=%0d miss=%0d, want 0 0", bus.score, bus.miss);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        frame("a", 0, 5, 1);
        set_gen("a", 1, 0, 2);
        bus.key_code = "a";
        @(posedge clk); #1;
        bus.frame_tick = 1; bus.key_valid = 1;
        @(posedge clk); #1;
        bus.frame_tick = 0; bus.key_valid = 0;
        repeat (2) @(posedge clk);
        #1 bus.key_valid = 1;
        @(posedge clk); #1;
        bus.key_valid = 0;
        wait_idle();
        model_frame("a", 1, 0, 2);
        model_key("a");
        snap();
        checks++;
        if (d_act[0] !== 1'b0 || d_act[1] !== 1'b1 || d_x[1] !== 9'd1 || bus.score !== 16'd1) begin
            errors++;
            $display("FAIL b2b: got s0=%0d s1=%0d x1=%0d score=%0d, want 0 1 1 1",
                     d_act[0], d_act[1], d_x[1], bus.score);
        end
        checks++;
        if (d_act[1] !== m_act[1] || bus.score !== 16'(m_score)) begin
            errors++;
            $display("FAIL b2b_model: got s1=%0d score=%0d, want %0d %0d",
                     d_act[1], bus.score, m_act[1], m_score);
        end
    endtask

    task automatic test_spawn_period();
        int n;
        logic a;
        logic [7:0] c;
        do_reset();
        for (int f = 1; f <= 7; f++) begin
            @(posedge clk); #1;
            bus3.gen_ch = 8'("A" + f);
            bus3.frame_tick = 1;
            @(posedge clk); #1;
            bus3.frame_tick = 0;
            repeat (14) @(posedge clk);
            n = 0;
            for (int i = 0; i < NS; i++) begin
                bus3.rd_idx = 3'(i);
                #1 a = bus3.rd_active;
                if (a === 1'b1) n++;
            end
            checks++;
            if (n != f / 3) begin
                errors++;
                $display("FAIL period_count_f%0d: got %0d, want %0d", f, n, f / 3);
            end
            if (f % 3 == 0) begin
                bus3.rd_idx = 3'(f / 3 - 1);
                #1 c = bus3.rd_ch;
                checks++;
                if (c !== 8'("A" + f)) begin
                    errors++;
                    $display("FAIL period_ch_f%0d: got %0d, want %0d", f, c, "A" + f);
                end
            end
        end
    endtask

    task automatic test_random();
        int r, ch, spd, x, y;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 2);
            if (r < 2) begin
                ch = "a" + $urandom_range(0, 3);
                spd = $urandom_range(0, 15);
                x = $urandom_range(0, 511);
                y = $urandom_range(0, 1023);
                frame(ch, spd, x, y);
            end else begin
                key("a" + $urandom_range(0, 3));
            end
            snap();
            for (int i = 0; i < NS; i++) begin
                checks++;
                if (d_act[i] !== m_act[i] || (m_act[i] && (d_ch[i] !== 8'(m_ch[i])
                    || d_x[i] !== 9'(m_x[i]) || d_y[i] !== 10'(m_y[i])))) begin
                    errors++;
                    $display("FAIL rand%0d_slot%0d: got act=%0d ch=%0d x=%0d y=%0d, want %0d %0d %0d %0d",
                             it, i, d_act[i], d_ch[i], d_x[i], d_y[i],
                             m_act[i], m_ch[i], m_x[i], m_y[i]);
                end
            end
            checks++;
            if (bus.score !== 16'(m_score) || bus.miss !== 16'(m_miss)) begin
                errors++;
                $display("FAIL rand%0d_counts: got score=%0d miss=%0d, want %0d %0d",
                         it, bus.score, bus.miss, m_score, m_miss);
            end
        end
    endtask

    task automatic test_game_over();
        logic exp_go;
`ifdef LETTER_POOL_GAMEOVER_EN
        exp_go = 1'b1;
`else
        exp_go = 1'b0;
`endif
        do_reset();
        frame("a", 15, 460, 0);
        frame("a", 15, 460, 0);
        checks++;
        if (bus.miss !== 16'd2 || bus.game_over !== exp_go) begin
            errors++;
            $display("FAIL gameover_set: got miss=%0d go=%0d, want 2 %0d",
                     bus.miss, bus.game_over, exp_go);
        end
        frame("b", 0, 0, 0);
        key("b");
        snap();
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (d_act[i] !== m_act[i] || (m_act[i] && d_ch[i] !== 8'(m_ch[i]))) begin
                errors++;
                $display("FAIL gameover_slot%0d: got act=%0d ch=%0d, want %0d %0d",
                         i, d_act[i], d_ch[i], m_act[i], m_ch[i]);
            end
        end
        checks++;
        if (bus.score !== 16'(m_score) || bus.game_over !== exp_go) begin
            errors++;
            $display("FAIL gameover_after: got score=%0d go=%0d, want %0d %0d",
                     bus.score, bus.game_over, m_score, exp_go);
        end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        frame("c", 0, 3, 3);
        set_gen("a", 15, 460, 0);
        pulse(1, 0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midmove_busy: got %0d, want 1", bus.busy);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({bus.score, bus.miss, bus.busy, bus.game_over} !== 34'd0) begin
            errors++;
            $display("FAIL midmove_status: got score=%0d miss=%0d busy=%0d go=%0d, want 0",
                     bus.score, bus.miss, bus.busy, bus.game_over);
        end
        snap();
        for (int i = 0; i < NS; i++) begin
            checks++;
            if ({d_act[i], d_ch[i], d_x[i], d_y[i]} !== 28'd0) begin
                errors++;
                $display("FAIL midmove_slot%0d: got act=%0d ch=%0d x=%0d, want 0",
                         i, d_act[i], d_ch[i], d_x[i]);
            end
        end
        @(posedge clk); #1 rst_n = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.score, bus.miss, bus.busy} !== 33'd0) begin
            errors++;
            $display("FAIL midmove_release: got score=%0d miss=%0d busy=%0d, want 0",
                     bus.score, bus.miss, bus.busy);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_spawn_move();
        test_miss();
        test_match();
        test_full();
        test_back_to_back();
        test_spawn_period();
        test_random();
        test_game_over();
        test_reset_mid_move();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
